rat_ckpt: RTL

RAT_CKPT -- requirements
Module: rat_ckpt

---
 rtl/rat_pkg.sv | 27 ++
 rtl/rat_ckpt_bank.sv | 39 +++
 rtl/rat_ckpt.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg -- shared definitions for the checkpointed register alias table.
//   ckpt_ptr_t : checkpoint head/tail/count type, wide enough for up to 32
//                slots plus a count of 32; users wrap it with ptr_mod().
//   nosrc_tag  : "no source operand" sentinel for a given tag width.
//   nord_tag   : "no destination" sentinel (all ones) for a given tag width.
// ---------------------------------------------------------------------------
package rat_pkg;

    localparam int unsigned CKPT_PTR_W = 6;

    typedef logic [CKPT_PTR_W-1:0] ckpt_ptr_t;

    function automatic int unsigned nosrc_tag(input int unsigned preg_w);
        return (32'd1 << preg_w) - 32'd2;
    endfunction

    function automatic int unsigned nord_tag(input int unsigned preg_w);
        return (32'd1 << preg_w) - 32'd1;
    endfunction

    // Modulo for a power-of-two slot count.
    function automatic ckpt_ptr_t ptr_mod(input ckpt_ptr_t p, input int unsigned n);
        return p & ckpt_ptr_t'(n - 1);
    endfunction

endpackage

// File: rtl/rat_ckpt_bank.sv
// ---------------------------------------------------------------------------
// rat_ckpt_bank -- snapshot storage for the rename map.
//   NUM_CKPT slots of MAP_W bits each, one full-width write port and one
//   full-width combinational read port. Contents are not reset; a slot is
//   only read after it has been written.
// Ports:
//   clk      : clock, rising edge
//   we_i     : write enable
//   waddr_i  : slot to write
//   wdata_i  : full map snapshot
//   raddr_i  : slot to read
//   rdata_o  : full map snapshot from raddr_i
// ---------------------------------------------------------------------------
module rat_ckpt_bank
    import rat_pkg::*;
#(
    parameter  int unsigned NUM_CKPT = 8,
    parameter  int unsigned MAP_W    = 256,
    localparam int unsigned CKPT_W   = $clog2(NUM_CKPT)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [CKPT_W-1:0] waddr_i,
    input  logic [MAP_W-1:0]  wdata_i,
    input  logic [CKPT_W-1:0] raddr_i,
    output logic [MAP_W-1:0]  rdata_o
);

    logic [MAP_W-1:0] slot_q [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (we_i) begin
            slot_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = slot_q[raddr_i];

endmodule

// File: rtl/rat_ckpt.sv
// ---------------------------------------------------------------------------
// rat_ckpt -- register alias table with branch checkpoints.
//   Renames one instruction per handshake (results registered one cycle
//   later), snapshots the post-rename map for branches, and restores a
//   snapshot on mispredict. Checkpoints form a FIFO of head/tail/count.
// Configuration macro:
//   RAT_CKPT_RESTORE_RENAME_EN : when defined, a rename may be accepted in
//   the same cycle as a restore and operates on the restored map; when
//   undefined, ren_ready is held low during restore cycles.
// Ports:
//   clk, reset (async, active low)
//   flush                        : return map to identity, drop checkpoints
//   ren_valid / ren_ready        : rename handshake
//   rs1/rs2/rd_arch, rs1/rs2_use, rd_we, free_preg, ckpt_req : rename request
//   restore_valid, restore_tag   : mispredict recovery
//   release_valid                : oldest checkpoint resolved
//   out_valid, rs1/rs2/rd/old_preg, ckpt_tag : registered rename result
//   ckpt_full, ckpt_count        : checkpoint occupancy
// ---------------------------------------------------------------------------
module rat_ckpt
    import rat_pkg::*;
#(
    parameter  int unsigned NUM_ARCH = 32,
    parameter  int unsigned PREG_W   = 8,
    parameter  int unsigned NUM_CKPT = 8,
    localparam int unsigned ARCH_W   = $clog2(NUM_ARCH),
    localparam int unsigned CKPT_W   = $clog2(NUM_CKPT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ren_valid,
    output logic              ren_ready,
    input  logic [ARCH_W-1:0] rs1_arch,
    input  logic [ARCH_W-1:0] rs2_arch,
    input  logic [ARCH_W-1:0] rd_arch,
    input  logic              rs1_use,
    input  logic              rs2_use,
    input  logic              rd_we,
    input  logic [PREG_W-1:0] free_preg,
    input  logic              ckpt_req,
    input  logic              restore_valid,
    input  logic [CKPT_W-1:0] restore_tag,
    input  logic              release_valid,
    output logic              out_valid,
    output logic [PREG_W-1:0] rs1_preg,
    output logic [PREG_W-1:0] rs2_preg,
    output logic [PREG_W-1:0] rd_preg,
    output logic [PREG_W-1:0] old_preg,
    output logic [CKPT_W-1:0] ckpt_tag,
    output logic              ckpt_full,
    output logic [CKPT_W:0]   ckpt_count
);

    localparam int unsigned MAP_W = NUM_ARCH * PREG_W;
    localparam logic [PREG_W-1:0] NOSRC = PREG_W'(nosrc_tag(PREG_W));
    localparam logic [PREG_W-1:0] NORD  = PREG_W'(nord_tag(PREG_W));
    localparam ckpt_ptr_t PTR_ONE  = ckpt_ptr_t'(1);
    localparam ckpt_ptr_t PTR_FULL = ckpt_ptr_t'(NUM_CKPT);

    function automatic logic [MAP_W-1:0] identity_map();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM_ARCH; k++) begin
            m[k*PREG_W +: PREG_W] = PREG_W'(k);
        end
        return m;
    endfunction

    localparam logic [MAP_W-1:0] ID_MAP = identity_map();

    logic [MAP_W-1:0]  map_q, map_d;
    ckpt_ptr_t         head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [PREG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, old_q, old_d;
    logic [CKPT_W-1:0] tag_q, tag_d;

    logic              hs, rel_ok, rst_ok, rd_wr;
    ckpt_ptr_t         rst_dist;
    logic [MAP_W-1:0]  base_map, post_map;
    logic              bank_we;
    logic [CKPT_W-1:0] bank_waddr;
    logic [MAP_W-1:0]  bank_rdata;

    rat_ckpt_bank #(
        .NUM_CKPT (NUM_CKPT),
        .MAP_W    (MAP_W)
    ) u_bank (
        .clk     (clk),
        .we_i    (bank_we),
        .waddr_i (bank_waddr),
        .wdata_i (post_map),
        .raddr_i (restore_tag),
        .rdata_o (bank_rdata)
    );

    assign ckpt_full  = (count_q == PTR_FULL);
    assign ckpt_count = count_q[CKPT_W:0];
    assign out_valid  = out_valid_q;
    assign rs1_preg   = rs1_q;
    assign rs2_preg   = rs2_q;
    assign rd_preg    = rd_q;
    assign old_preg   = old_q;
    assign ckpt_tag   = tag_q;

    always_comb begin
        ren_ready = !flush && !(ckpt_full && ckpt_req);
`ifndef RAT_CKPT_RESTORE_RENAME_EN
        ren_ready = ren_ready && !restore_valid;
`endif
    end

    always_comb begin
        hs       = ren_valid && ren_ready;
        rel_ok   = release_valid && (count_q != '0);
        // Age of the restore tag relative to head; live iff younger than count.
        rst_dist = ptr_mod(ckpt_ptr_t'(restore_tag) - head_q, NUM_CKPT);
        rst_ok   = restore_valid && (rst_dist < count_q);
        base_map = rst_ok ? bank_rdata : map_q;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst_ok) begin
            tail_d = ckpt_ptr_t'(restore_tag);
            // Release-first: restoring the slot being released leaves the pool
            // empty with head parked at the restored tag (head == tail).
            if (rel_ok && (rst_dist != '0)) begin
                head_d  = ptr_mod(head_q + PTR_ONE, NUM_CKPT);
                count_d = rst_dist - PTR_ONE;
            end else begin
                count_d = rst_dist;
            end
        end else if (rel_ok) begin
            head_d  = ptr_mod(head_q + PTR_ONE, NUM_CKPT);
            count_d = count_q - PTR_ONE;
        end

        // Rename reads the pre-update (possibly restored) map.
        rd_wr    = rd_we && (rd_arch != '0);
        post_map = base_map;
        if (rd_wr) begin
            post_map[int'(rd_arch)*PREG_W +: PREG_W] = free_preg;
        end

        out_valid_d = hs;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        rd_d  = rd_q;
        old_d = old_q;
        tag_d = tag_q;
        if (hs) begin
            rs1_d = rs1_use ? base_map[int'(rs1_arch)*PREG_W +: PREG_W] : NOSRC;
            rs2_d = rs2_use ? base_map[int'(rs2_arch)*PREG_W +: PREG_W] : NOSRC;
            rd_d  = rd_wr ? free_preg : NORD;
            old_d = rd_wr ? base_map[int'(rd_arch)*PREG_W +: PREG_W] : free_preg;
        end

        bank_we    = hs && ckpt_req;
        bank_waddr = tail_d[CKPT_W-1:0];
        if (bank_we) begin
            tag_d   = tail_d[CKPT_W-1:0];
            tail_d  = ptr_mod(tail_d + PTR_ONE, NUM_CKPT);
            count_d = count_d + PTR_ONE;
        end

        map_d = hs ? post_map : base_map;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            map_q       <= ID_MAP;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            rs1_q       <= NOSRC;
            rs2_q       <= NOSRC;
            rd_q        <= NORD;
            old_q       <= '0;
            tag_q       <= '0;
        end else if (flush) begin
            map_q       <= ID_MAP;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            map_q       <= map_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            old_q       <= old_d;
            tag_q       <= tag_d;
        end
    end

endmodule
